// File: rtl/serial_frame_tx_if.sv
// Bundle of the transmitter's request, bit-rate enable and serial line signals.
interface serial_frame_tx_if #(
  parameter int PORT_W = 2,
  parameter int LEN_W  = 4
);
  localparam int DATA_W = 2**LEN_W - 1;

  logic              clkEN;
  logic              start;
  logic [PORT_W-1:0] port;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] data;
  logic              SerOut;
  logic              busy;
  logic              serOut_valid;
  logic              done;

  // Frame source side: drives the request and the bit-rate enable.
  modport master (
    output clkEN, start, port, len, data,
    input  SerOut, busy, serOut_valid, done
  );

  // Transmitter side.
  modport slave (
    input  clkEN, start, port, len, data,
    output SerOut, busy, serOut_valid, done
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, port field, length field, then len
// payload bits, all MSB first, one bit per clkEN edge. The line idles high.
module serial_frame_tx #(
  parameter int PORT_W = 2,
  parameter int LEN_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  serial_frame_tx_if.slave   bus
);
  localparam int DATA_W = 2**LEN_W - 1;
  localparam int MAX_N  = (DATA_W > PORT_W) ? ((DATA_W > LEN_W) ? DATA_W : LEN_W)
                                            : ((PORT_W > LEN_W) ? PORT_W : LEN_W);
  localparam int SH_W   = MAX_N;
  localparam int CNT_W  = $clog2(MAX_N + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // State names the bit currently on the line.
  typedef enum logic [2:0] {IDLE, ARMED, START, PORT, LEN, DATA} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;      // bits left in the current field after this one
  logic [SH_W-1:0]   sh_q, sh_d;        // current field, left-aligned; MSB is on the line
  logic [PORT_W-1:0] port_q, port_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ser_q, ser_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  // Each field is left-aligned in the shifter so its first bit sits at the MSB.
  // The payload is aligned so that data[len-1] is sent first and bits above it never are.
  logic [SH_W-1:0] port_al, len_al, data_al, sh_shift;
  assign port_al  = SH_W'(port_q) << (SH_W - PORT_W);
  assign len_al   = SH_W'(len_q)  << (SH_W - LEN_W);
  assign data_al  = SH_W'(data_q) << (SH_W - int'(len_q));
  assign sh_shift = sh_q << 1;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    port_d  = port_q;
    len_d   = len_q;
    data_d  = data_q;
    ser_d   = ser_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        ser_d   = 1'b1;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        cnt_d   = '0;
        if (bus.start) begin
          port_d  = bus.port;
          len_d   = bus.len;
          data_d  = bus.data;
          busy_d  = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: if (bus.clkEN) begin
        ser_d   = 1'b0;
        state_d = START;
      end
      START: if (bus.clkEN) begin
        sh_d    = port_al;
        ser_d   = port_al[SH_W-1];
        cnt_d   = CNT_W'(PORT_W - 1);
        state_d = PORT;
      end
      PORT: if (bus.clkEN) begin
        if (cnt_q == '0) begin
          sh_d    = len_al;
          ser_d   = len_al[SH_W-1];
          cnt_d   = CNT_W'(LEN_W - 1);
          state_d = LEN;
        end else begin
          sh_d  = sh_shift;
          ser_d = sh_shift[SH_W-1];
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      LEN: if (bus.clkEN) begin
        if (cnt_q != '0) begin
          sh_d  = sh_shift;
          ser_d = sh_shift[SH_W-1];
          cnt_d = cnt_q - CNT_ONE;
        end else if (len_q != '0) begin
          sh_d    = data_al;
          ser_d   = data_al[SH_W-1];
          cnt_d   = CNT_W'(len_q) - CNT_ONE;
          valid_d = 1'b1;
          state_d = DATA;
        end else begin
          ser_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      DATA: if (bus.clkEN) begin
        if (cnt_q == '0) begin
          ser_d   = 1'b1;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          sh_d  = sh_shift;
          ser_d = sh_shift[SH_W-1];
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured fields and registered outputs; reset aborts any frame at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: captured fields are cleared too, so an aborted frame leaves nothing behind.
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      port_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      ser_q   <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      port_q  <= port_d;
      len_q   <= len_d;
      data_q  <= data_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.SerOut       = ser_q;
  assign bus.busy         = busy_q;
  assign bus.serOut_valid = valid_q;
  assign bus.done         = done_q;
endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Transmit-side controller and datapath for the lab serial framing protocol. It accepts a port number, a payload length and a payload word in parallel. It then drives them onto a single serial line as a start bit, port field, length field and payload bits, paced by a bit-rate enable. It is the counterpart to the existing serial frame receiver and is intended to be looped back to it on the lab board.

## Interface
- PORT_W, 2, width of the port-number field in bits
- LEN_W, 4, width of the length field in bits; payload register width is derived as DATA_W = 2**LEN_W - 1 (15 by default)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately
- clkEN  input  1  bit-rate enable; one serial bit period = one clk edge with clkEN=1
- start  input  1  request to send a frame; sampled on every clk edge
- port  input  PORT_W  port number to send; captured on accept
- len  input  LEN_W  payload bit count (0..DATA_W); captured on accept
- data  input  DATA_W  payload; bits data[len-1:0] are sent; captured on accept
- SerOut  output  1  serial line; idles high
- busy  output  1  frame accepted and not yet finished
- serOut_valid  output  1  high while SerOut carries a payload bit
- done  output  1  one-clk pulse at end of frame

## Operation
- States: IDLE, ARMED, START, PORT, LEN, DATA. The state names which bit is currently on the line.
- IDLE:
  - SerOut=1, busy=0.
  - On a clk edge with start=1, capture port/len/data into internal registers and go to ARMED.
  - The capture edge does not need clkEN.
- ARMED:
  - SerOut=1, busy=1.
  - Waits for the first clkEN edge, then goes to START.
- START: SerOut=0 for one bit period, then goes to PORT.
- PORT:
  - Sends port MSB first, PORT_W bit periods, using a bit counter.
  - After the last port bit, goes to LEN.
- LEN:
  - Sends len MSB first, LEN_W bit periods.
  - After the last bit, goes to DATA if len≠0, else to IDLE.
- DATA:
  - Sends data[len-1] down to data[0], len bit periods; serOut_valid=1 throughout.
  - After the last bit, goes to IDLE.
- done asserts for exactly one clk cycle, the first cycle back in IDLE after a completed frame.
- start while busy=1 is ignored. The captured fields are stable for the whole frame regardless of input changes.
- Payload bits above len-1 are never transmitted.
- The bit counter is wide enough for max(PORT_W, LEN_W, DATA_W). It reloads on each field change and never wraps mid-field.

## Timing
- Reset values: SerOut=1, busy=0, serOut_valid=0, done=0, state=IDLE, counters=0.
- Reset mid-frame aborts immediately (asynchronously): the line goes high, no done pulse, and captured fields are discarded.
- All outputs are registered. SerOut changes only on clkEN edges, apart from reset.
- Latency: the start bit appears on the first clkEN edge strictly after the accept edge.
- Frame length on the line: 1 + PORT_W + LEN_W + len bit periods.
- The clk edge that returns to IDLE sets SerOut=1 and done=1.
- Back-to-back frames: start=1 during the done cycle is accepted on that edge. The minimum idle gap on the line is one bit period, the next frame's ARMED period.
- clkEN held low stalls the frame with SerOut held; there is no timeout.
- If clkEN=1 on the accept edge, that edge only accepts. The start bit is driven on the next clkEN edge.

## Test plan
- Reset check: assert reset low mid-operation -> SerOut=1, busy=0, serOut_valid=0, done=0 without waiting for a clk edge.
- Basic frame, clkEN=1 every cycle:
  - Stimulus: port=2'b10, len=3, data=15'h0005.
  - Required SerOut over the bit periods: 0, 1,0, 0,0,1,1, 1,0,1, then 1.
  - serOut_valid high for exactly the last 3 bits; done for one cycle; busy high for 11 cycles.
- Zero-length frame: port=2'b01, len=0 -> SerOut 0, 0,1, 0,0,0,0, then idle high, with serOut_valid never high and done pulsing.
- Paced enable, clkEN=1 one cycle in four, len=15, data=15'h7FFF:
  - Every bit holds for 4 clk cycles.
  - 15 consecutive ones are sent after the fields.
  - Changing the data/port inputs mid-frame has no effect on SerOut.
- Start while busy: pulse start during the PORT state -> ignored and the frame is unchanged.
- Back-to-back frames: start held at 1 -> the second frame's start bit follows exactly one high bit period after the first frame's last bit.
